// File: rtl/generator_pwm_motoare.sv
// Two-channel H-bridge output stage: shared PWM counter, per-channel STOP/RUN/DEAD FSM
// with boundary-synchronous duty update, soft-start ramp and coast dead-time on reversal.
module generator_pwm_motoare #(
  parameter logic [11:0] CNT_MAX      = 12'h999,
  parameter logic [3:0]  DEAD_PERIODS = 4'd2,
  parameter logic [11:0] RAMP_START   = 12'h200,
  parameter logic [11:0] RAMP_STEP    = 12'h100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  directie_driverA_in,
  input  logic [1:0]  directie_driverB_in,
  input  logic [11:0] factor_dc_driverA,
  input  logic [11:0] factor_dc_driverB,
  output logic [1:0]  directie_driverA,
  output logic [1:0]  directie_driverB,
  output logic        pwm_driverA,
  output logic        pwm_driverB,
  output logic        sincron_perioada
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } ch_state_t;

  logic [11:0] cnt;
  logic        boundary;

  ch_state_t [1:0]   state;
  logic [1:0][1:0]   dir_q;
  logic [1:0][12:0]  duty_q;
  logic [1:0][3:0]   dead_q;
  logic [1:0]        pwm_q;

  logic [1:0][1:0]   req;
  logic [1:0][11:0]  factor;
  logic [1:0][12:0]  tgt;
  logic [1:0][12:0]  start_duty;
  logic [1:0][13:0]  ramp_sum;
  logic [1:0][12:0]  ramp_duty;
  logic [1:0]        stop_req;

  assign boundary = (cnt == CNT_MAX);

  always_comb begin
    req[0]    = directie_driverA_in;
    req[1]    = directie_driverB_in;
    factor[0] = factor_dc_driverA;
    factor[1] = factor_dc_driverB;
  end

  // Duty is held in 13 bits so a target above CNT_MAX saturates to a true 100%.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      tgt[i] = (factor[i] > CNT_MAX) ? ({1'b0, CNT_MAX} + 13'd1) : {1'b0, factor[i]};
      start_duty[i] = ({1'b0, RAMP_START} < tgt[i]) ? {1'b0, RAMP_START} : tgt[i];
      ramp_sum[i] = {1'b0, duty_q[i]} + {2'b00, RAMP_STEP};
      if (tgt[i] > duty_q[i]) begin
        ramp_duty[i] = (ramp_sum[i] >= {1'b0, tgt[i]}) ? tgt[i] : ramp_sum[i][12:0];
      end else begin
        ramp_duty[i] = tgt[i];
      end
      stop_req[i] = !enable || (req[i] == 2'b00) || (req[i] == 2'b11);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt              <= '0;
      sincron_perioada <= 1'b0;
      dir_q            <= '0;
      duty_q           <= '0;
      dead_q           <= '0;
      pwm_q            <= '0;
      for (int i = 0; i < 2; i++) begin
        state[i] <= ST_STOP;
      end
    end else begin
      cnt              <= boundary ? 12'd0 : cnt + 12'd1;
      sincron_perioada <= boundary;
      for (int i = 0; i < 2; i++) begin
        if (stop_req[i]) begin
          state[i]  <= ST_STOP;
          dir_q[i]  <= 2'b00;
          duty_q[i] <= '0;
          dead_q[i] <= '0;
          pwm_q[i]  <= 1'b0;
        end else if (boundary) begin
          case (state[i])
            ST_RUN: begin
              if (req[i] == dir_q[i]) begin
                duty_q[i] <= ramp_duty[i];
                pwm_q[i]  <= ({1'b0, cnt} < duty_q[i]);
              end else if (DEAD_PERIODS != 4'd0) begin
                state[i]  <= ST_DEAD;
                dead_q[i] <= DEAD_PERIODS;
                dir_q[i]  <= 2'b00;
                duty_q[i] <= '0;
                pwm_q[i]  <= 1'b0;
              end else begin
                dir_q[i]  <= req[i];
                duty_q[i] <= start_duty[i];
                pwm_q[i]  <= 1'b0;
              end
            end
            ST_DEAD: begin
              pwm_q[i] <= 1'b0;
              if (dead_q[i] <= 4'd1) begin
                state[i]  <= ST_RUN;
                dir_q[i]  <= req[i];
                duty_q[i] <= start_duty[i];
                dead_q[i] <= '0;
              end else begin
                dead_q[i] <= dead_q[i] - 4'd1;
              end
            end
            default: begin
              state[i]  <= ST_RUN;
              dir_q[i]  <= req[i];
              duty_q[i] <= start_duty[i];
              pwm_q[i]  <= 1'b0;
            end
          endcase
        end else begin
          pwm_q[i] <= (state[i] == ST_RUN) && ({1'b0, cnt} < duty_q[i]);
        end
      end
    end
  end

  assign directie_driverA = dir_q[0];
  assign directie_driverB = dir_q[1];
  assign pwm_driverA      = pwm_q[0];
  assign pwm_driverB      = pwm_q[1];

endmodule

// File: tb/tb_generator_pwm_motoare.sv
// Bench for generator_pwm_motoare: two instances (with and without dead time) share random
// stimulus; a reference model pushes per-cycle expected outputs, a monitor pops and compares.
module tb_generator_pwm_motoare;

  localparam int CM  = 9;
  localparam int RS  = 3;
  localparam int STP = 2;
  localparam int M_STOP = 0;
  localparam int M_RUN  = 1;
  localparam int M_DEAD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  da = 2'b00, db = 2'b00;
  logic [11:0] fa = '0, fb = '0;

  logic [1:0] d0_dir_a, d0_dir_b, d1_dir_a, d1_dir_b;
  logic       d0_pwm_a, d0_pwm_b, d0_sync, d1_pwm_a, d1_pwm_b, d1_sync;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  generator_pwm_motoare #(.CNT_MAX(12'd9), .DEAD_PERIODS(4'd2), .RAMP_START(12'd3),
                          .RAMP_STEP(12'd2)) dut0 (
    .clk(clk), .rst(rst), .enable(enable),
    .directie_driverA_in(da), .directie_driverB_in(db),
    .factor_dc_driverA(fa), .factor_dc_driverB(fb),
    .directie_driverA(d0_dir_a), .directie_driverB(d0_dir_b),
    .pwm_driverA(d0_pwm_a), .pwm_driverB(d0_pwm_b), .sincron_perioada(d0_sync));

  generator_pwm_motoare #(.CNT_MAX(12'd9), .DEAD_PERIODS(4'd0), .RAMP_START(12'd3),
                          .RAMP_STEP(12'd2)) dut1 (
    .clk(clk), .rst(rst), .enable(enable),
    .directie_driverA_in(da), .directie_driverB_in(db),
    .factor_dc_driverA(fa), .factor_dc_driverB(fb),
    .directie_driverA(d1_dir_a), .directie_driverB(d1_dir_b),
    .pwm_driverA(d1_pwm_a), .pwm_driverB(d1_pwm_b), .sincron_perioada(d1_sync));

  // ---------------- reference model ----------------
  int         dead_cfg [2] = '{2, 0};
  int         m_mode [2][2];
  logic [1:0] m_dir  [2][2];
  int         m_duty [2][2];
  int         m_dead [2][2];
  logic       m_pwm  [2][2];
  int         m_cnt;
  logic       m_sync;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        m_mode[k][c] = M_STOP; m_dir[k][c] = 2'b00; m_duty[k][c] = 0;
        m_dead[k][c] = 0;      m_pwm[k][c] = 1'b0;
      end
    end
    m_cnt  = 0;
    m_sync = 1'b0;
  endfunction

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // One clock edge of the whole system given the inputs held across it.
  function automatic void model_edge(logic en, logic [1:0] ra, logic [1:0] rb,
                                     logic [11:0] ta, logic [11:0] tb);
    bit at_end = (m_cnt == CM);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        logic [1:0] r = (c == 0) ? ra : rb;
        int tgt = min2(int'((c == 0) ? ta : tb), CM + 1);
        int old_mode = m_mode[k][c];
        logic [1:0] old_dir = m_dir[k][c];
        int old_duty = m_duty[k][c];
        if (!en || r == 2'b00 || r == 2'b11) begin
          m_mode[k][c] = M_STOP; m_dir[k][c] = 2'b00; m_duty[k][c] = 0; m_dead[k][c] = 0;
        end else if (at_end) begin
          bit restart = 1'b0;
          if (old_mode == M_STOP) restart = 1'b1;
          else if (old_mode == M_RUN) begin
            if (r == old_dir) m_duty[k][c] = (tgt > old_duty) ? min2(old_duty + STP, tgt) : tgt;
            else if (dead_cfg[k] > 0) begin
              m_mode[k][c] = M_DEAD; m_dead[k][c] = dead_cfg[k];
              m_dir[k][c] = 2'b00;   m_duty[k][c] = 0;
            end else restart = 1'b1;
          end else begin
            m_dead[k][c] = m_dead[k][c] - 1;
            if (m_dead[k][c] == 0) restart = 1'b1;
          end
          if (restart) begin
            m_mode[k][c] = M_RUN; m_dir[k][c] = r; m_duty[k][c] = min2(RS, tgt);
          end
        end
        // The sample taken at an edge only survives if the channel keeps running one way.
        m_pwm[k][c] = (old_mode == M_RUN) && (m_mode[k][c] == M_RUN) &&
                      (m_dir[k][c] == old_dir) && (m_cnt < old_duty);
      end
    end
    m_cnt  = at_end ? 0 : m_cnt + 1;
    m_sync = (m_cnt == 0);
  endfunction

  function automatic logic [6:0] exp_of(int k);
    return {m_dir[k][0], m_dir[k][1], m_pwm[k][0], m_pwm[k][1], m_sync};
  endfunction

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [13:0] e_cur;
  logic [6:0]  act0, act1;

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      act0 = {d0_dir_a, d0_dir_b, d0_pwm_a, d0_pwm_b, d0_sync};
      act1 = {d1_dir_a, d1_dir_b, d1_pwm_a, d1_pwm_b, d1_sync};
      vectors += 2;
      if (act0 !== e_cur[13:7]) begin
        miscompares++;
        $display("FAIL dut0_outputs cyc=%0d got dirA=%b dirB=%b pwmA=%b pwmB=%b sync=%b expected dirA=%b dirB=%b pwmA=%b pwmB=%b sync=%b",
                 cyc, act0[6:5], act0[4:3], act0[2], act0[1], act0[0],
                 e_cur[13:12], e_cur[11:10], e_cur[9], e_cur[8], e_cur[7]);
      end
      if (act1 !== e_cur[6:0]) begin
        miscompares++;
        $display("FAIL dut1_outputs cyc=%0d got dirA=%b dirB=%b pwmA=%b pwmB=%b sync=%b expected dirA=%b dirB=%b pwmA=%b pwmB=%b sync=%b",
                 cyc, act1[6:5], act1[4:3], act1[2], act1[1], act1[0],
                 e_cur[6:5], e_cur[4:3], e_cur[2], e_cur[1], e_cur[0]);
      end
    end
  end

  // ---------------- driver ----------------
  logic        s_rst = 1'b1, s_en = 1'b0;
  logic [1:0]  s_da = 2'b00, s_db = 2'b00;
  logic [11:0] s_fa = '0, s_fb = '0;
  logic        p_rst = 1'b1, p_en = 1'b0;
  logic [1:0]  p_da = 2'b00, p_db = 2'b00;
  logic [11:0] p_fa = '0, p_fb = '0;

  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      if (p_rst) model_reset();
      else model_edge(p_en, p_da, p_db, p_fa, p_fb);
      #1;
      rst = s_rst; enable = s_en; da = s_da; db = s_db; fa = s_fa; fb = s_fb;
      if (s_rst) model_reset();
      exp_q.push_back({exp_of(0), exp_of(1)});
      p_rst = s_rst; p_en = s_en; p_da = s_da; p_db = s_db; p_fa = s_fa; p_fb = s_fb;
    end
  endtask

  function automatic logic [1:0] rand_dir();
    int r = $urandom_range(0, 9);
    if (r < 4) return 2'b10;
    if (r < 8) return 2'b01;
    if (r == 8) return 2'b00;
    return 2'b11;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    tick(3);
    // Ramp from STOP: fwd A to 8, rev B to 5.
    s_rst = 1'b0; s_en = 1'b1; s_da = 2'b10; s_db = 2'b01; s_fa = 12'd8; s_fb = 12'd5;
    tick(62);
    s_fa = 12'd2;   tick(25);
    s_fa = 12'hFFF; tick(30);
    s_fa = 12'd0;   tick(12);
    s_fa = 12'd10;  tick(15);
    // Reversal, and a request that flips back during the coast.
    s_fa = 12'd7; s_da = 2'b01; tick(55);
    s_da = 2'b10; tick(7);
    s_da = 2'b01; tick(33);
    s_en = 1'b0; tick(13);
    s_en = 1'b1; tick(40);
    s_da = 2'b11; tick(7);
    s_da = 2'b10; tick(35);
    s_rst = 1'b1; tick(2);
    s_rst = 1'b0; tick(25);
    s_db = 2'b10; s_da = 2'b01; tick(45);
    for (int n = 0; n < 160; n++) begin
      s_da = rand_dir();
      s_db = rand_dir();
      s_fa = 12'($urandom_range(0, 15));
      s_fb = 12'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) s_fa = 12'hFFF;
      s_en = ($urandom_range(0, 19) != 0);
      s_rst = ($urandom_range(0, 39) == 0);
      if (s_rst) begin
        tick($urandom_range(1, 2));
        s_rst = 1'b0;
      end
      tick($urandom_range(1, 35));
    end
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
